// File: rtl/combination_ctrl.sv
// Sequencer for the combination phase: loads each weight column once, then
// walks every feature row through read, MAC and a backpressured result write.
module combination_ctrl #(
    parameter int FEATURE_ROWS  = 6,
    parameter int WEIGHT_COLS   = 3,
    parameter int FEATURE_WIDTH = $clog2(FEATURE_ROWS),
    parameter int WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     read_weight,
    output logic [WEIGHT_WIDTH-1:0]  weight_addr,
    output logic                     load_weight,
    output logic                     read_feature,
    output logic [FEATURE_WIDTH-1:0] feature_addr,
    output logic                     mac_en,
    output logic                     wr_en,
    input  logic                     wr_ready,
    output logic [FEATURE_WIDTH-1:0] wr_row,
    output logic [WEIGHT_WIDTH-1:0]  wr_col,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_WAIT_W  = 3'd2,
        S_FEAT_RD = 3'd3,
        S_MAC     = 3'd4,
        S_WRITE   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [FEATURE_WIDTH-1:0] ROW_LAST = FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [WEIGHT_WIDTH-1:0]  COL_LAST = WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [FEATURE_WIDTH-1:0] r_row;
    logic [FEATURE_WIDTH-1:0] w_row_nxt;
    logic [WEIGHT_WIDTH-1:0]  r_col;
    logic [WEIGHT_WIDTH-1:0]  w_col_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
        end
    end

    // Counters only move on an accepted write (or when a pass starts).
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_W;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_LOAD_W:  w_state_nxt = S_WAIT_W;
            S_WAIT_W:  w_state_nxt = S_FEAT_RD;
            S_FEAT_RD: w_state_nxt = S_MAC;
            S_MAC:     w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (wr_ready) begin
                    if (r_row < ROW_LAST) begin
                        w_row_nxt   = r_row + FEATURE_WIDTH'(1);
                        w_state_nxt = S_FEAT_RD;
                    end else if (r_col < COL_LAST) begin
                        w_row_nxt   = '0;
                        w_col_nxt   = r_col + WEIGHT_WIDTH'(1);
                        w_state_nxt = S_LOAD_W;
                    end else begin
                        w_row_nxt   = '0;
                        w_col_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        read_weight  = 1'b0;
        load_weight  = 1'b0;
        read_feature = 1'b0;
        mac_en       = 1'b0;
        wr_en        = 1'b0;
        done         = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_LOAD_W:  read_weight  = 1'b1;
            S_WAIT_W:  load_weight  = 1'b1;
            S_FEAT_RD: read_feature = 1'b1;
            S_MAC:     mac_en       = 1'b1;
            S_WRITE:   wr_en        = 1'b1;
            S_DONE:    done         = 1'b1;
            default: ;
        endcase
    end

    assign weight_addr  = r_col;
    assign wr_col       = r_col;
    assign feature_addr = r_row;
    assign wr_row       = r_row;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_combination_ctrl.sv
// Bench for combination_ctrl: randomized write backpressure checked cycle by
// cycle against an expected step sequence built from the pass structure.
module tb_combination_ctrl;

    localparam int K_IDLE = 0;
    localparam int K_LW   = 1;
    localparam int K_WW   = 2;
    localparam int K_RF   = 3;
    localparam int K_MC   = 4;
    localparam int K_WR   = 5;
    localparam int K_DN   = 6;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rw;
        logic [3:0] wa;
        logic       lw;
        logic       rf;
        logic [3:0] fa;
        logic       mac;
        logic       wr;
        logic [3:0] wrr;
        logic [3:0] wrc;
    } out_t;

    typedef struct {
        int kind;
        int row;
        int col;
    } step_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // default-parameter instance
    logic       start_d, ready_d;
    logic       rw_d, lw_d, rf_d, mac_d, wr_d, busy_d, done_d;
    logic [1:0] wa_d, wrc_d;
    logic [2:0] fa_d, wrr_d, dbg_d;
    out_t       obs_d;

    // swept instance (4 rows, 2 columns)
    logic       start_s, ready_s;
    logic       rw_s, lw_s, rf_s, mac_s, wr_s, busy_s, done_s;
    logic [0:0] wa_s, wrc_s;
    logic [1:0] fa_s, wrr_s;
    logic [2:0] dbg_s;
    out_t       obs_s;

    step_t exp_q[$];

    combination_ctrl dut (
        .clk(clk), .reset(reset), .start(start_d),
        .read_weight(rw_d), .weight_addr(wa_d), .load_weight(lw_d),
        .read_feature(rf_d), .feature_addr(fa_d), .mac_en(mac_d),
        .wr_en(wr_d), .wr_ready(ready_d), .wr_row(wrr_d), .wr_col(wrc_d),
        .busy(busy_d), .done(done_d), .dbg_state(dbg_d)
    );

    combination_ctrl #(.FEATURE_ROWS(4), .WEIGHT_COLS(2)) dut_s (
        .clk(clk), .reset(reset), .start(start_s),
        .read_weight(rw_s), .weight_addr(wa_s), .load_weight(lw_s),
        .read_feature(rf_s), .feature_addr(fa_s), .mac_en(mac_s),
        .wr_en(wr_s), .wr_ready(ready_s), .wr_row(wrr_s), .wr_col(wrc_s),
        .busy(busy_s), .done(done_s), .dbg_state(dbg_s)
    );

    assign obs_d = {busy_d, done_d, rw_d, 4'(wa_d), lw_d, rf_d, 4'(fa_d),
                    mac_d, wr_d, 4'(wrr_d), 4'(wrc_d)};
    assign obs_s = {busy_s, done_s, rw_s, 4'(wa_s), lw_s, rf_s, 4'(fa_s),
                    mac_s, wr_s, 4'(wrr_s), 4'(wrc_s)};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t exp_of(input step_t s);
        out_t e;
        e = '0;
        if (s.kind != K_IDLE) begin
            e.busy = 1'b1;
            e.wa   = 4'(s.col);
            e.wrc  = 4'(s.col);
            e.fa   = 4'(s.row);
            e.wrr  = 4'(s.row);
            case (s.kind)
                K_LW: e.rw   = 1'b1;
                K_WW: e.lw   = 1'b1;
                K_RF: e.rf   = 1'b1;
                K_MC: e.mac  = 1'b1;
                K_WR: e.wr   = 1'b1;
                K_DN: e.done = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input out_t o, input out_t e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start_s = v; else start_d = v;
    endtask

    task automatic set_ready(input int sel, input logic v);
        if (sel != 0) ready_s = v; else ready_d = v;
    endtask

    task automatic idle_chk(input int sel, input int n, input string tag);
        step_t idle_step;
        idle_step = '{K_IDLE, 0, 0};
        for (int i = 0; i < n; i++) begin
            chk(tag, (sel != 0) ? obs_s : obs_d, exp_of(idle_step));
            @(negedge clk);
        end
    endtask

    // Called at a negedge with the DUT idle. mode: 0 ready always,
    // 1 four-cycle stall on write (2,1) plus ignored start pulses,
    // 2 random ready. hold keeps start high; abort resets during write (4,2).
    task automatic do_pass(input int sel, input int rows, input int cols,
                           input int mode, input bit hold, input bit abort,
                           input string tag);
        step_t cur;
        out_t  o;
        logic  rdy;
        int    cyc, stalls, rw_cnt, wr_cnt, done_cyc, stall_left;
        bit    aborted;
        exp_q.delete();
        for (int c = 0; c < cols; c++) begin
            exp_q.push_back('{K_LW, 0, c});
            exp_q.push_back('{K_WW, 0, c});
            for (int r = 0; r < rows; r++) begin
                exp_q.push_back('{K_RF, r, c});
                exp_q.push_back('{K_MC, r, c});
                exp_q.push_back('{K_WR, r, c});
            end
        end
        exp_q.push_back('{K_DN, 0, 0});
        cyc = 1; stalls = 0; rw_cnt = 0; wr_cnt = 0; done_cyc = -1;
        stall_left = 4; aborted = 1'b0;
        set_start(sel, 1'b1);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            if (cyc > 400) begin
                chk_int({tag, "_timeout"}, cyc, 400);
                exp_q.delete();
                break;
            end
            cur = exp_q[0];
            o = (sel != 0) ? obs_s : obs_d;
            chk($sformatf("%s_cyc%0d", tag, cyc), o, exp_of(cur));
            if (o.rw) rw_cnt++;
            if (o.done) done_cyc = cyc;
            rdy = 1'b1;
            if (cur.kind == K_WR) begin
                if (mode == 1 && cur.row == 2 && cur.col == 1 && stall_left > 0) begin
                    rdy = 1'b0;
                    stall_left--;
                end else if (mode == 2) begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
            end
            set_ready(sel, rdy);
            if (abort && cur.kind == K_WR && cur.row == 4 && cur.col == 2) begin
                set_ready(sel, 1'b0);
                #2 reset = 1'b0;
                #1 chk({tag, "_async_rst"}, obs_d, '0);
                aborted = 1'b1;
                exp_q.delete();
                break;
            end
            if (cur.kind == K_WR) begin
                if (rdy) begin
                    if (o.wr) wr_cnt++;
                    void'(exp_q.pop_front());
                end else begin
                    stalls++;
                end
            end else begin
                void'(exp_q.pop_front());
            end
            if (!hold)
                set_start(sel, (mode == 1) && (cyc == 30 || cyc == 50 || cur.kind == K_DN));
            @(negedge clk);
            cyc++;
        end
        set_ready(sel, 1'b1);
        if (!aborted) begin
            chk_int({tag, "_done_cycle"}, done_cyc, 1 + cols * (2 + 3 * rows) + stalls);
            chk_int({tag, "_rw_count"}, rw_cnt, cols);
            chk_int({tag, "_wr_count"}, wr_cnt, rows * cols);
        end else begin
            chk_int({tag, "_no_done"}, done_cyc, -1);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0;
        start_d = 1'b0; ready_d = 1'b1;
        start_s = 1'b0; ready_s = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_d", obs_d, '0);
        chk("reset_s", obs_s, '0);
        reset = 1'b1;
        @(negedge clk);
        idle_chk(0, 2, "idle_after_reset");

        do_pass(0, 6, 3, 0, 1'b0, 1'b0, "basic");
        chk_int("basic_stalls_free_done", 1 + 3 * (2 + 3 * 6), 61);
        set_start(0, 1'b0);
        idle_chk(0, 2, "idle_basic");

        do_pass(0, 6, 3, 1, 1'b0, 1'b0, "stall");
        set_start(0, 1'b0);
        idle_chk(0, 3, "idle_stall");

        do_pass(0, 6, 3, 0, 1'b1, 1'b0, "hold1");
        chk("hold_idle_one", obs_d, '0);
        do_pass(0, 6, 3, 0, 1'b0, 1'b0, "hold2");
        set_start(0, 1'b0);
        idle_chk(0, 2, "idle_hold");

        do_pass(0, 6, 3, 2, 1'b0, 1'b0, "rand");
        set_start(0, 1'b0);
        idle_chk(0, 2, "idle_rand");

        do_pass(0, 6, 3, 0, 1'b0, 1'b1, "abort");
        set_start(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_held%0d", i), obs_d, '0);
        end
        reset = 1'b1;
        @(negedge clk);
        idle_chk(0, 1, "idle_after_abort");
        do_pass(0, 6, 3, 2, 1'b0, 1'b0, "fresh");
        set_start(0, 1'b0);
        idle_chk(0, 1, "idle_fresh");

        do_pass(1, 4, 2, 0, 1'b0, 1'b0, "sweep");
        set_start(1, 1'b0);
        idle_chk(1, 2, "idle_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/combination_ctrl.md
Name: combination_ctrl

Overview:
- Sequencer for the Combination phase (feature matrix × weight matrix).
- For each weight column it loads the column once, then walks every feature row: read, MAC, write the result element.
- Drives the feature/weight memory read ports, the MAC enable, and the output-matrix write port (with backpressure).
- Sits between the top-level start/done control and the combination datapath.

Parameters:
- FEATURE_ROWS, 6, rows of the feature matrix (≥2).
- WEIGHT_COLS, 3, columns of the weight matrix (≥2).
- FEATURE_WIDTH, $clog2(FEATURE_ROWS), width of the row index.
- WEIGHT_WIDTH, $clog2(WEIGHT_COLS), width of the column index.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin one full combination pass; sampled in IDLE only.
- read_weight  output  1  weight memory read enable.
- weight_addr  output  WEIGHT_WIDTH  weight column being loaded.
- load_weight  output  1  datapath captures the weight column (data valid this cycle).
- read_feature  output  1  feature memory read enable.
- feature_addr  output  FEATURE_WIDTH  feature row being read.
- mac_en  output  1  datapath computes the dot product (feature data valid this cycle).
- wr_en  output  1  output write request; held until accepted.
- wr_ready  input  1  output memory accepts the write this cycle.
- wr_row  output  FEATURE_WIDTH  output element row.
- wr_col  output  WEIGHT_WIDTH  output element column.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the pass completes.

Behaviour:
- Registers are the state, row counter (row) and column counter (col).
- Reset (reset=0, asynchronous): state=IDLE, row=0, col=0; all outputs 0.
- Outputs are decoded from registered state/counters only. There is no combinational path from start or wr_ready to any output.
- Addresses equal the counters:
  - weight_addr = wr_col = col.
  - feature_addr = wr_row = row.
- Memories have fixed 1-cycle read latency.

States and transitions:
- IDLE: busy=0. On start=1, go to LOAD_W with row=0, col=0.
- LOAD_W: read_weight=1. Next state: WAIT_W.
- WAIT_W: load_weight=1. Next state: FEAT_RD.
- FEAT_RD: read_feature=1. Next state: MAC.
- MAC: mac_en=1. Next state: WRITE.
- WRITE: wr_en=1; row/col stable while wr_ready=0 (stall indefinitely). On wr_ready=1:
  - row<FEATURE_ROWS-1: row++, go to FEAT_RD.
  - else if col<WEIGHT_COLS-1: row=0, col++, go to LOAD_W.
  - else: row=0, col=0, go to DONE.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE.

Boundary conditions:
- start while busy (including in DONE): ignored, no restart or queueing.
- start held high: a new pass begins on the cycle after returning to IDLE.
- Counters never wrap past their limits. row is reset explicitly at the last row; col at the last column.
- Reset asserted mid-pass: immediate return to IDLE; no done pulse; wr_en drops asynchronously.

Timing:
- Cycles per column: 2 + 3·FEATURE_ROWS with no stalls.
- Full pass: WEIGHT_COLS·(2+3·FEATURE_ROWS) cycles, then one DONE cycle. Defaults: 60 busy-working cycles, done in cycle 61 after start is accepted.
- Each wr_ready=0 cycle in WRITE adds exactly one cycle.

Test Plan:
- Defaults, wr_ready tied 1, start pulsed once:
  - busy rises the next cycle; done pulses exactly once, 61 cycles after the start edge.
  - 18 wr_en handshakes in order (0,0),(1,0)…(5,0),(0,1)…(5,2).
  - read_weight asserted 3 times with addr 0,1,2.
- Backpressure: wr_ready=0 for 4 cycles on the write of (2,1):
  - wr_en, wr_row=2, wr_col=1 held stable for those cycles.
  - done delayed by exactly 4 cycles (cycle 65).
- Per-row sequencing: check every read_feature is followed one cycle later by mac_en with the same feature_addr, then wr_en the next cycle. Check load_weight follows read_weight by exactly one cycle.
- start held high continuously:
  - pulses at cycles 30 and 50 of the pass have no effect.
  - after done, IDLE lasts 1 cycle, then a second pass starts from (0,0).
- Async reset (reset=0) asserted mid-WRITE of (4,2):
  - all outputs 0 immediately, no done.
  - after release, start yields a fresh pass beginning with weight_addr=0.
- Parameter sweep FEATURE_ROWS=4, WEIGHT_COLS=2, wr_ready=1: done at cycle 2·(2+12)+1=29; 8 writes observed.
